// File: rtl/sha256_pkg.sv
// Shared SHA-256 message-schedule constants, small-sigma helpers and FSM state type.
package sha256_pkg;

   localparam int unsigned ROUNDS = 64;
   localparam int unsigned WIN    = 16;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} msched_st_t;

   localparam logic [31:0] K [ROUNDS] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   function automatic logic [31:0] sig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] sig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

endpackage

// File: rtl/msg_sched_wt_if.sv
// Handshake bundle: message words in, (r_cntr, kt, wt) round beats out.
interface msg_sched_wt_if;

   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_word;
   logic        out_valid;
   logic        out_ready;
   logic [5:0]  r_cntr;
   logic [31:0] kt;
   logic [31:0] wt;
   logic        last;
   logic        done;
   logic [5:0]  tag;

   modport master (
      output in_valid, in_word, out_ready,
      input  in_ready, out_valid, r_cntr, kt, wt, last, done, tag
   );

   modport slave (
      input  in_valid, in_word, out_ready,
      output in_ready, out_valid, r_cntr, kt, wt, last, done, tag
   );

endinterface

// File: rtl/w_expand.sv
// Combinational schedule step: W[t] from W[t-2], W[t-7], W[t-15], W[t-16], mod 2^32.
module w_expand
   import sha256_pkg::*;
(
   input  logic [31:0] i_w2,
   input  logic [31:0] i_w7,
   input  logic [31:0] i_w15,
   input  logic [31:0] i_w16,
   output logic [31:0] o_wnext
);

   assign o_wnext = sig1(i_w2) + i_w7 + sig0(i_w15) + i_w16;

endmodule

// File: rtl/msg_sched_wt.sv
// Loads a 16-word message block, then streams (round, K, W) for rounds 0..63.
module msg_sched_wt
   import sha256_pkg::*;
#(
   parameter logic [3:0] CORE = 4'b0,
   parameter logic [1:0] SHA  = 2'b0
) (
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_en,
   msg_sched_wt_if.slave  bus
);

   msched_st_t  r_state;
   logic [3:0]  r_ld_cnt;
   logic [31:0] r_win [WIN];
   logic        r_in_ready;
   logic        r_out_valid;
   logic [5:0]  r_cntr;
   logic [31:0] r_kt;
   logic [31:0] r_wt;
   logic        r_last;
   logic        r_done;

   logic [31:0] w_wnext;
   logic [5:0]  w_cntr_nxt;

   assign w_cntr_nxt = r_cntr + 6'd1;

   // Window holds W[t..t+15] while beat t is presented; slot 0 is the live wt.
   w_expand u_w_expand (
      .i_w2    (r_win[14]),
      .i_w7    (r_win[9]),
      .i_w15   (r_win[1]),
      .i_w16   (r_win[0]),
      .o_wnext (w_wnext)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_state     <= IDLE;
         r_ld_cnt    <= '0;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_cntr      <= '0;
         r_kt        <= '0;
         r_wt        <= '0;
         r_last      <= 1'b0;
         r_done      <= 1'b0;
         for (int i = 0; i < WIN; i++) r_win[i] <= '0;
      end else if (i_en) begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_state    <= LOAD;
               r_in_ready <= 1'b1;
               r_ld_cnt   <= '0;
            end
            LOAD: begin
               if (bus.in_valid && r_in_ready) begin
                  for (int i = 0; i < WIN - 1; i++) r_win[i] <= r_win[i+1];
                  r_win[WIN-1] <= bus.in_word;
                  r_ld_cnt     <= r_ld_cnt + 4'd1;
                  if (r_ld_cnt == 4'(WIN - 1)) begin
                     // r_win[1] becomes slot 0 (M0) after this shift
                     r_state     <= RUN;
                     r_in_ready  <= 1'b0;
                     r_out_valid <= 1'b1;
                     r_cntr      <= '0;
                     r_kt        <= K[0];
                     r_wt        <= r_win[1];
                     r_last      <= 1'b0;
                  end
               end
            end
            RUN: begin
               if (bus.out_ready) begin
                  for (int i = 0; i < WIN - 1; i++) r_win[i] <= r_win[i+1];
                  r_win[WIN-1] <= w_wnext;
                  if (r_cntr == 6'(ROUNDS - 1)) begin
                     r_state     <= DONE;
                     r_out_valid <= 1'b0;
                     r_last      <= 1'b0;
                     r_done      <= 1'b1;
                     r_cntr      <= '0;
                     r_kt        <= '0;
                     r_wt        <= '0;
                  end else begin
                     r_cntr <= w_cntr_nxt;
                     r_kt   <= K[w_cntr_nxt];
                     r_wt   <= r_win[1];
                     r_last <= (w_cntr_nxt == 6'(ROUNDS - 1));
                  end
               end
            end
            DONE: begin
               r_state    <= LOAD;
               r_in_ready <= 1'b1;
               r_ld_cnt   <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = r_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.r_cntr    = r_cntr;
   assign bus.kt        = r_kt;
   assign bus.wt        = r_wt;
   assign bus.last      = r_last;
   assign bus.done      = r_done;
   assign bus.tag       = {CORE, SHA};

endmodule
